// File: rtl/jtag_tap_pkg.sv
// -----------------------------------------------------------------------------
// jtag_tap_pkg
// Shared definitions for the JTAG TAP responder:
//   - tap_state_e : the 16 IEEE 1149.1 TAP controller states with their
//                   standard 4-bit encodings (Test-Logic-Reset = 4'hF).
//   - opcode constants for IDCODE, USERDATA and BYPASS, and the fixed
//     Capture-IR pattern.
//   - dr_sel_e    : which data register the current instruction selects.
//   - tap_next()  : standard TMS-driven state transition function.
// -----------------------------------------------------------------------------
package jtag_tap_pkg;

   typedef enum logic [3:0] {
      TAP_EXIT2_DR   = 4'h0,
      TAP_EXIT1_DR   = 4'h1,
      TAP_SHIFT_DR   = 4'h2,
      TAP_PAUSE_DR   = 4'h3,
      TAP_SELECT_IR  = 4'h4,
      TAP_UPDATE_DR  = 4'h5,
      TAP_CAPTURE_DR = 4'h6,
      TAP_SELECT_DR  = 4'h7,
      TAP_EXIT2_IR   = 4'h8,
      TAP_EXIT1_IR   = 4'h9,
      TAP_SHIFT_IR   = 4'hA,
      TAP_PAUSE_IR   = 4'hB,
      TAP_RTI        = 4'hC,
      TAP_UPDATE_IR  = 4'hD,
      TAP_CAPTURE_IR = 4'hE,
      TAP_TLR        = 4'hF
   } tap_state_e;

   localparam logic [3:0] OPC_IDCODE   = 4'b0001;
   localparam logic [3:0] OPC_USERDATA = 4'b0010;
   localparam logic [3:0] OPC_BYPASS   = 4'b1111;

   // Loaded on Capture-IR; the 01 in the LSBs lets a probe find the IR
   // boundary in a chain.
   localparam logic [3:0] IR_CAPTURE   = 4'b0101;

   typedef enum logic [1:0] {
      DR_IDCODE,
      DR_USER,
      DR_BYPASS
   } dr_sel_e;

   // Standard TAP controller transition on a TCK rise.
   function automatic tap_state_e tap_next(input tap_state_e s, input logic tms);
      tap_state_e n;
      n = TAP_TLR;
      case (s)
         TAP_TLR:        n = tms ? TAP_TLR       : TAP_RTI;
         TAP_RTI:        n = tms ? TAP_SELECT_DR : TAP_RTI;
         TAP_SELECT_DR:  n = tms ? TAP_SELECT_IR : TAP_CAPTURE_DR;
         TAP_CAPTURE_DR: n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_SHIFT_DR:   n = tms ? TAP_EXIT1_DR  : TAP_SHIFT_DR;
         TAP_EXIT1_DR:   n = tms ? TAP_UPDATE_DR : TAP_PAUSE_DR;
         TAP_PAUSE_DR:   n = tms ? TAP_EXIT2_DR  : TAP_PAUSE_DR;
         TAP_EXIT2_DR:   n = tms ? TAP_UPDATE_DR : TAP_SHIFT_DR;
         TAP_UPDATE_DR:  n = tms ? TAP_SELECT_DR : TAP_RTI;
         TAP_SELECT_IR:  n = tms ? TAP_TLR       : TAP_CAPTURE_IR;
         TAP_CAPTURE_IR: n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_SHIFT_IR:   n = tms ? TAP_EXIT1_IR  : TAP_SHIFT_IR;
         TAP_EXIT1_IR:   n = tms ? TAP_UPDATE_IR : TAP_PAUSE_IR;
         TAP_PAUSE_IR:   n = tms ? TAP_EXIT2_IR  : TAP_PAUSE_IR;
         TAP_EXIT2_IR:   n = tms ? TAP_UPDATE_IR : TAP_SHIFT_IR;
         TAP_UPDATE_IR:  n = tms ? TAP_SELECT_DR : TAP_RTI;
         default:        n = TAP_TLR;
      endcase
      return n;
   endfunction

endpackage

// File: rtl/jtag_sync.sv
// -----------------------------------------------------------------------------
// jtag_sync
// Two-flop synchronizer for one asynchronous JTAG input, with optional
// single-CLK rise/fall event pulses derived from the synchronized value and
// its previous sample.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, clears the chain to 0
//   async_in : asynchronous input
//   sync_out : synchronized level (2 CLK latency)
//   rise     : one-CLK pulse on a synchronized 0->1 (0 when EDGE_EN = 0)
//   fall     : one-CLK pulse on a synchronized 1->0 (0 when EDGE_EN = 0)
// -----------------------------------------------------------------------------
module jtag_sync #(
   parameter bit EDGE_EN = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic async_in,
   output logic sync_out,
   output logic rise,
   output logic fall
);

   logic [1:0] sync_q;
   logic [1:0] sync_d;

   // NOTE: every signal assigned in always_comb gets a value on every path,
   // otherwise a latch is inferred.
   always_comb begin
      sync_d = {sync_q[0], async_in};
   end

   // NOTE: sequential state uses non-blocking assignments only, so all flops
   // sample the pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign sync_out = sync_q[1];

   generate
      if (EDGE_EN) begin : g_edge
         logic prev_q;
         logic prev_d;

         always_comb begin
            prev_d = sync_q[1];
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               prev_q <= 1'b0;
            end else begin
               prev_q <= prev_d;
            end
         end

         assign rise = sync_q[1] & ~prev_q;
         assign fall = ~sync_q[1] & prev_q;
      end else begin : g_no_edge
         assign rise = 1'b0;
         assign fall = 1'b0;
      end
   endgenerate

endmodule

// File: rtl/jtag_tap_responder.sv
// -----------------------------------------------------------------------------
// jtag_tap_responder
// Minimal IEEE 1149.1 TAP that runs entirely on the system clock. The probe's
// TCK/TMS/TDI/nTRST are oversampled; TCK edges become single-CLK events that
// advance the TAP state machine (rise) and launch TDO (fall).
// Instructions: IDCODE (32-bit DR), USERDATA (8-bit DR), BYPASS (1-bit DR).
// Ports:
//   CLK, RST     : system clock, synchronous active-high reset
//   TCK,TMS,TDI  : asynchronous JTAG inputs
//   nTRST        : asynchronous test reset, active-low
//   TDO, TDO_OE  : test data out and its drive enable
//   RTCK         : synchronized TCK registered once (3-CLK lag)
//   TAP_STATE    : current TAP state code
//   IR_Q         : current instruction
//   USER_Q       : USERDATA register
//   USER_UPD     : one-CLK pulse when USERDATA is updated
// -----------------------------------------------------------------------------
module jtag_tap_responder
   import jtag_tap_pkg::*;
#(
   parameter logic [31:0] IDCODE = 32'h1BB1A5A3,
   parameter int          IR_LEN = 4
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              TCK,
   input  logic              TMS,
   input  logic              TDI,
   input  logic              nTRST,
   output logic              TDO,
   output logic              TDO_OE,
   output logic              RTCK,
   output logic [3:0]        TAP_STATE,
   output logic [IR_LEN-1:0] IR_Q,
   output logic [7:0]        USER_Q,
   output logic              USER_UPD
);

   // ---------------------------------------------------------------------------
   // Input synchronizers
   // ---------------------------------------------------------------------------
   logic tck_s, tck_rise, tck_fall;
   logic tms_s, tdi_s, trst_n_s;
   logic unused_tms_rise, unused_tms_fall;
   logic unused_tdi_rise, unused_tdi_fall;
   logic unused_trst_rise, unused_trst_fall;

   jtag_sync #(.EDGE_EN(1'b1)) u_sync_tck (
      .clk      (CLK),
      .rst      (RST),
      .async_in (TCK),
      .sync_out (tck_s),
      .rise     (tck_rise),
      .fall     (tck_fall)
   );

   jtag_sync #(.EDGE_EN(1'b0)) u_sync_tms (
      .clk      (CLK),
      .rst      (RST),
      .async_in (TMS),
      .sync_out (tms_s),
      .rise     (unused_tms_rise),
      .fall     (unused_tms_fall)
   );

   jtag_sync #(.EDGE_EN(1'b0)) u_sync_tdi (
      .clk      (CLK),
      .rst      (RST),
      .async_in (TDI),
      .sync_out (tdi_s),
      .rise     (unused_tdi_rise),
      .fall     (unused_tdi_fall)
   );

   // Clears to 0 under RST, which reads as "test reset asserted" for two
   // CLKs after RST releases; the TAP is already in Test-Logic-Reset then.
   jtag_sync #(.EDGE_EN(1'b0)) u_sync_trst (
      .clk      (CLK),
      .rst      (RST),
      .async_in (nTRST),
      .sync_out (trst_n_s),
      .rise     (unused_trst_rise),
      .fall     (unused_trst_fall)
   );

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   tap_state_e        state_q,     state_d;
   logic [IR_LEN-1:0] ir_sr_q,     ir_sr_d;
   logic [31:0]       dr_sr_q,     dr_sr_d;
   logic [IR_LEN-1:0] instr_q,     instr_d;
   logic [7:0]        user_data_q, user_data_d;
   logic              user_upd_q,  user_upd_d;
   logic              tdo_q,       tdo_d;
   logic              tdo_oe_q,    tdo_oe_d;
   logic              rtck_q,      rtck_d;

   dr_sel_e dr_sel;

   // Unknown opcodes fall back to BYPASS.
   always_comb begin
      if (instr_q == IR_LEN'(OPC_IDCODE)) begin
         dr_sel = DR_IDCODE;
      end else if (instr_q == IR_LEN'(OPC_USERDATA)) begin
         dr_sel = DR_USER;
      end else begin
         dr_sel = DR_BYPASS;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d     = state_q;
      ir_sr_d     = ir_sr_q;
      dr_sr_d     = dr_sr_q;
      instr_d     = instr_q;
      user_data_d = user_data_q;
      user_upd_d  = 1'b0;
      tdo_d       = tdo_q;
      tdo_oe_d    = tdo_oe_q;
      rtck_d      = tck_s;

      if (!trst_n_s) begin
         // Test reset wins over any TCK event; TDO is released at once
         // rather than waiting for a TCK fall.
         state_d  = TAP_TLR;
         instr_d  = IR_LEN'(OPC_IDCODE);
         tdo_d    = 1'b0;
         tdo_oe_d = 1'b0;
      end else if (tck_rise) begin
         // Register actions belong to the state being left on this rise.
         case (state_q)
            TAP_CAPTURE_IR: ir_sr_d = IR_LEN'(IR_CAPTURE);
            TAP_SHIFT_IR:   ir_sr_d = {tdi_s, ir_sr_q[IR_LEN-1:1]};
            TAP_CAPTURE_DR: begin
               case (dr_sel)
                  DR_IDCODE: dr_sr_d = IDCODE;
                  DR_USER:   dr_sr_d = {24'h0, user_data_q};
                  default:   dr_sr_d = '0;
               endcase
            end
            TAP_SHIFT_DR: begin
               // TDI enters at the MSB of the selected register's length so
               // the bit order out of TDO matches the register width.
               case (dr_sel)
                  DR_IDCODE: dr_sr_d = {tdi_s, dr_sr_q[31:1]};
                  DR_USER:   dr_sr_d = {24'h0, tdi_s, dr_sr_q[7:1]};
                  default:   dr_sr_d = {31'h0, tdi_s};
               endcase
            end
            default: ;
         endcase

         state_d = tap_next(state_q, tms_s);

         // Updates happen on the rise that enters the Update state; the
         // shift register is untouched in Exit1/Exit2, so the _q copy is final.
         if (state_d == TAP_UPDATE_IR) begin
            instr_d = ir_sr_q;
         end
         if (state_d == TAP_UPDATE_DR && dr_sel == DR_USER) begin
            user_data_d = dr_sr_q[7:0];
            user_upd_d  = 1'b1;
         end
         if (state_d == TAP_TLR) begin
            instr_d = IR_LEN'(OPC_IDCODE);
         end
      end else if (tck_fall) begin
         tdo_oe_d = (state_q == TAP_SHIFT_IR) || (state_q == TAP_SHIFT_DR);
         if (state_q == TAP_SHIFT_IR) begin
            tdo_d = ir_sr_q[0];
         end else if (state_q == TAP_SHIFT_DR) begin
            tdo_d = dr_sr_q[0];
         end else begin
            tdo_d = 1'b0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   // NOTE: the shift registers are reset too, so a scan interrupted by RST
   // leaves nothing behind that a later Update could commit.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q     <= TAP_TLR;
         ir_sr_q     <= '0;
         dr_sr_q     <= '0;
         instr_q     <= IR_LEN'(OPC_IDCODE);
         user_data_q <= '0;
         user_upd_q  <= 1'b0;
         tdo_q       <= 1'b0;
         tdo_oe_q    <= 1'b0;
         rtck_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         ir_sr_q     <= ir_sr_d;
         dr_sr_q     <= dr_sr_d;
         instr_q     <= instr_d;
         user_data_q <= user_data_d;
         user_upd_q  <= user_upd_d;
         tdo_q       <= tdo_d;
         tdo_oe_q    <= tdo_oe_d;
         rtck_q      <= rtck_d;
      end
   end

   assign TDO       = tdo_q;
   assign TDO_OE    = tdo_oe_q;
   assign RTCK      = rtck_q;
   assign TAP_STATE = state_q;
   assign IR_Q      = instr_q;
   assign USER_Q    = user_data_q;
   assign USER_UPD  = user_upd_q;

endmodule

// File: doc/jtag_tap_responder.md
JTAG_TAP_RESPONDER -- requirements
Module: jtag_tap_responder

Interface
REQ-001 SHALL have parameter IDCODE, default 32'h1BB1A5A3, the value returned by the IDCODE instruction; bit 0 SHALL be 1.
REQ-002 SHALL have parameter IR_LEN, default 4, the instruction register width.
REQ-003 SHALL have port CLK, input, 1, the single system clock for all state.
REQ-004 SHALL have port RST, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port TCK, input, 1, asynchronous JTAG test clock from the probe.
REQ-006 SHALL have port TMS, input, 1, asynchronous test mode select.
REQ-007 SHALL have port TDI, input, 1, asynchronous test data in.
REQ-008 SHALL have port nTRST, input, 1, asynchronous test reset, active-low.
REQ-009 SHALL have port TDO, output, 1, test data out.
REQ-010 SHALL have port TDO_OE, output, 1, TDO drive enable, high = driven.
REQ-011 SHALL have port RTCK, output, 1, returned test clock.
REQ-012 SHALL have port TAP_STATE, output, 4, current TAP state code.
REQ-013 SHALL have port IR_Q, output, IR_LEN, current instruction.
REQ-014 SHALL have port USER_Q, output, 8, USERDATA register contents.
REQ-015 SHALL have port USER_UPD, output, 1, one-CLK pulse on USERDATA update.

Function
REQ-016 TCK, TMS, TDI and nTRST SHALL each pass a 2-flop synchronizer on CLK before use.
REQ-017 TCK rise/fall SHALL be detected from the synchronized TCK and its previous sample; each edge yields exactly one CLK-wide event.
REQ-018 TCK high and low times SHALL each be at least 3 CLK periods; faster TCK is out of scope.
REQ-019 RTCK SHALL equal the synchronized TCK, registered once, so it lags TCK by 3 CLK.
REQ-020 The TAP FSM SHALL implement all 16 IEEE 1149.1 states with standard TMS transitions, advancing only on TCK rise events.
REQ-021 Five consecutive TCK rises with TMS=1 SHALL reach Test-Logic-Reset from any state.
REQ-022 Synchronized nTRST=0 SHALL force Test-Logic-Reset on the next CLK edge, overriding any TCK event.
REQ-023 In Test-Logic-Reset, IR_Q SHALL be IDCODE opcode 4'b0001.
REQ-024 Opcodes SHALL be 4'b0001 IDCODE (32-bit DR), 4'b0010 USERDATA (8-bit DR), and 4'b1111 BYPASS; all others select BYPASS.
REQ-025 Capture-IR SHALL load 4'b0101 into the IR shift register, with LSBs 01.
REQ-026 Capture-DR SHALL load IDCODE, USER_Q, or 1'b0 (BYPASS) into the selected shift register.
REQ-027 In Shift-IR/Shift-DR, each TCK rise SHALL shift TDI in at the MSB and shift out at the LSB.
REQ-028 Update-IR SHALL copy the IR shift register to IR_Q on the TCK rise that enters Update-IR.
REQ-029 Update-DR with USERDATA SHALL copy the DR shift register to USER_Q and pulse USER_UPD for 1 CLK.
REQ-030 TDO and TDO_OE SHALL change only on TCK fall events: TDO = shift-register LSB, TDO_OE = 1 only while in Shift-IR or Shift-DR.
REQ-031 TDO SHALL be 0 whenever TDO_OE = 0.
REQ-032 If a TCK rise and fall event coincide, which cannot occur under REQ-018, the rise SHALL take priority.

Reset
REQ-033 When RST=1, all synchronizers SHALL clear to 0 and the FSM SHALL enter Test-Logic-Reset.
REQ-034 When RST=1: IR_Q = 4'b0001, USER_Q = 8'h00, TDO = 0, TDO_OE = 0, RTCK = 0, USER_UPD = 0, TAP_STATE = Test-Logic-Reset code.
REQ-035 RST during a shift SHALL discard the partial shift; no update SHALL occur.

Structure
REQ-036 Package jtag_tap_pkg SHALL hold the 16 TAP state codes (Test-Logic-Reset = 4'hF, per IEEE state encoding) and the opcode constants.
REQ-037 Sub-module jtag_sync SHALL provide one 2-flop synchronizer, with optional rise/fall event outputs; it SHALL be instantiated per input.

Verification
REQ-038 Reset, then 5 TCK with TMS=1, then Shift-DR and 32 TCK -> TDO stream equals 32'h1BB1A5A3, LSB first; TDO_OE=1 only during the shift.
REQ-039 Load IR=4'b1111, then shift 8'b10110010 through DR -> TDO repeats the pattern delayed by one TCK, first bit 0.
REQ-040 Load IR=4'b0010, shift in 8'hA5, then Update-DR -> USER_Q=8'hA5 and a single USER_UPD pulse; a second scan then reads 8'hA5.
REQ-041 Shift-IR capture -> first 4 TDO bits are 1,0,1,0 (4'b0101, LSB first).
REQ-042 nTRST low mid Shift-DR -> TAP_STATE = 4'hF and TDO_OE=0 within 3 CLK; USER_Q unchanged.
REQ-043 RST asserted mid-scan -> all REQ-034 values on the next CLK; RTCK tracks TCK with a 3-CLK lag afterward.
